// File: rtl/ifm_fetch_controller.sv
// Input-feature-map fetch controller: reads 4-beat groups from a fixed-latency RAM,
// packs each group into one wide word and hands it downstream with a valid/ready handshake.
module ifm_fetch_controller #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         num_groups,
    output logic                rd_en_next,
    output logic [ADDR_W-1:0]   addr_ram_next_rd,
    input  logic [BEAT_W-1:0]   rd_data,
    output logic [4*BEAT_W-1:0] ifm_data_out,
    output logic                ifm_data_valid,
    input  logic                ifm_ready,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0]        beat_cnt;
    logic [15:0]       rem_cnt;

    // Latency pipe: one slot per RAM cycle, carrying "a beat is in flight" and its lane.
    logic              pipe_vld  [RD_LAT];
    logic [1:0]        pipe_beat [RD_LAT];
    logic              tap_vld;
    logic [1:0]        tap_beat;
    logic              last_beat_back;
    logic              handshake;

    assign tap_vld        = pipe_vld[RD_LAT-1];
    assign tap_beat       = pipe_beat[RD_LAT-1];
    assign last_beat_back = tap_vld && (tap_beat == 2'd3);

    // ifm_data_valid/ifm_ready: a group transfers on every rising edge where both are
    // high; once valid rises, it and ifm_data_out hold until that edge; ready alone does nothing.
    assign handshake      = ifm_data_valid && ifm_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (num_groups == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (beat_cnt == 2'd3) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (last_beat_back) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_nx = (rem_cnt <= 16'd1) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        rd_en_next       = (state == S_READ);
        addr_ram_next_rd = addr_cnt;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        dbg_state        = state;
    end

    // Address, beat and remaining-group counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt <= '0;
            beat_cnt <= 2'd0;
            rem_cnt  <= 16'd0;
        end else begin
            if (state == S_IDLE && start) begin
                addr_cnt <= base_addr;
                rem_cnt  <= num_groups;
                beat_cnt <= 2'd0;
            end else if (state == S_READ) begin
                addr_cnt <= addr_cnt + 1'b1;
                beat_cnt <= beat_cnt + 2'd1;
            end
            if (state == S_HOLD && handshake && rem_cnt != 16'd0) begin
                rem_cnt <= rem_cnt - 16'd1;
            end
        end
    end

    // Latency pipe shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_beat[i] <= 2'd0;
            end
        end else begin
            pipe_vld[0]  <= rd_en_next;
            pipe_beat[0] <= beat_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_beat[i] <= pipe_beat[i-1];
            end
        end
    end

    // Lane capture; lanes not written keep the previous group's data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifm_data_out <= '0;
        end else if (tap_vld) begin
            ifm_data_out[int'(tap_beat)*BEAT_W +: BEAT_W] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifm_data_valid <= 1'b0;
        end else if (state == S_WAIT && last_beat_back) begin
            ifm_data_valid <= 1'b1;
        end else if (handshake) begin
            ifm_data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifm_fetch_controller.sv
// Bench for ifm_fetch_controller: two instances (RD_LAT=1 and RD_LAT=3) share stimulus;
// a job-level model pushes expected addresses/groups into queues that per-DUT monitors pop.
module tb_ifm_fetch_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr;
    logic [15:0]  num_groups;
    logic         ifm_ready;

    logic         rd_en1, valid1, busy1, done1;
    logic [31:0]  addr1, rd_data1;
    logic [127:0] data1;
    logic [2:0]   st1;
    logic         rd_en3, valid3, busy3, done3;
    logic [31:0]  addr3, rd_data3;
    logic [127:0] data3;
    logic [2:0]   st3;

    ifm_fetch_controller #(.ADDR_W(32), .BEAT_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_groups(num_groups),
        .rd_en_next(rd_en1), .addr_ram_next_rd(addr1), .rd_data(rd_data1),
        .ifm_data_out(data1), .ifm_data_valid(valid1), .ifm_ready(ifm_ready),
        .busy(busy1), .done(done1), .dbg_state(st1)
    );

    ifm_fetch_controller #(.ADDR_W(32), .BEAT_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_groups(num_groups),
        .rd_en_next(rd_en3), .addr_ram_next_rd(addr3), .rd_data(rd_data3),
        .ifm_data_out(data3), .ifm_data_valid(valid3), .ifm_ready(ifm_ready),
        .busy(busy3), .done(done3), .dbg_state(st3)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters / scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0]  exp_a1[$];
    logic [31:0]  exp_a3[$];
    logic [127:0] exp_g1[$];
    logic [127:0] exp_g3[$];
    int exp_done1 = 0, exp_done3 = 0, got_done1 = 0, got_done3 = 0;
    int first_rd1, valid_cyc1, done_cyc1, busy_cnt1;
    int first_rd3, valid_cyc3, done_cyc3, busy_cnt3;
    logic [127:0] first_grp1;
    bit data_is_addr = 1'b1;
    bit rand_ready   = 1'b0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_evt(input string name, input logic [127:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h expected nothing (t=%0t)", name, act, $time);
    endfunction

    // RAM content: either the address itself or a scrambled value of it
    function automatic logic [31:0] dval(input logic [31:0] a);
        return data_is_addr ? a : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    // ---------------- RAM models (fixed latency 1 and 3) ----------------
    logic [31:0] dp1;
    logic [31:0] dp3 [3];
    always @(posedge clk) begin
        dp1    <= rd_en1 ? dval(addr1) : $urandom;
        dp3[0] <= rd_en3 ? dval(addr3) : $urandom;
        dp3[1] <= dp3[0];
        dp3[2] <= dp3[1];
    end
    assign rd_data1 = dp1;
    assign rd_data3 = dp3[2];

    // ---------------- reference model: whole job -> expected streams ----------------
    task automatic push_job(input logic [31:0] base, input int n);
        logic [127:0] grp;
        logic [31:0]  a;
        for (int g = 0; g < n; g++) begin
            for (int k = 0; k < 4; k++) begin
                a = base + 32'(4 * g + k);
                exp_a1.push_back(a);
                exp_a3.push_back(a);
                grp[k*32 +: 32] = dval(a);
            end
            exp_g1.push_back(grp);
            exp_g3.push_back(grp);
        end
        exp_done1++;
        exp_done3++;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en1) begin
                if (first_rd1 < 0) first_rd1 = cyc;
                if (exp_a1.size() == 0) fail_evt("addr1_extra", addr1);
                else chk("addr1", addr1, exp_a1.pop_front());
                chk("rd_in_hold1", valid1, 1'b0);
            end
            if (valid1) begin
                if (valid_cyc1 < 0) begin
                    valid_cyc1 = cyc;
                    first_grp1 = data1;
                end
                if (exp_g1.size() == 0) fail_evt("grp1_extra", data1);
                else begin
                    chk("grp1", data1, exp_g1[0]);
                    if (ifm_ready) void'(exp_g1.pop_front());
                end
            end
            if (done1) begin
                if (done_cyc1 < 0) done_cyc1 = cyc;
                got_done1++;
            end
            if (busy1) busy_cnt1++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en3) begin
                if (first_rd3 < 0) first_rd3 = cyc;
                if (exp_a3.size() == 0) fail_evt("addr3_extra", addr3);
                else chk("addr3", addr3, exp_a3.pop_front());
                chk("rd_in_hold3", valid3, 1'b0);
            end
            if (valid3) begin
                if (valid_cyc3 < 0) valid_cyc3 = cyc;
                if (exp_g3.size() == 0) fail_evt("grp3_extra", data3);
                else begin
                    chk("grp3", data3, exp_g3[0]);
                    if (ifm_ready) void'(exp_g3.pop_front());
                end
            end
            if (done3) begin
                if (done_cyc3 < 0) done_cyc3 = cyc;
                got_done3++;
            end
            if (busy3) busy_cnt3++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        first_rd1 = -1; valid_cyc1 = -1; done_cyc1 = -1; busy_cnt1 = 0;
        first_rd3 = -1; valid_cyc3 = -1; done_cyc3 = -1; busy_cnt3 = 0;
    endtask

    task automatic start_job(input logic [31:0] base, input int n, output int s);
        base_addr  = base;
        num_groups = 16'(n);
        start      = 1'b1;
        s          = cyc;
        push_job(base, n);
        tick();
        start      = 1'b0;
        base_addr  = $urandom;
        num_groups = 16'($urandom_range(0, 9));
    endtask

    task automatic wait_idle(input int max, input bit junk);
        int t;
        t = 0;
        while ((busy1 || busy3) && t < max) begin
            if (rand_ready) ifm_ready = ($urandom_range(0, 3) != 0);
            if (junk && busy1 && busy3 && $urandom_range(0, 4) == 0) start = 1'b1;
            tick();
            start = 1'b0;
            t++;
        end
        if (busy1 || busy3) fail_evt("idle_timeout", {busy1, busy3});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, {rd_en1, rd_en3}, 2'b00);
        chk({tag, "_addr"},  {addr1, addr3}, 64'h0);
        chk({tag, "_data1"}, data1, 128'h0);
        chk({tag, "_data3"}, data3, 128'h0);
        chk({tag, "_valid"}, {valid1, valid3}, 2'b00);
        chk({tag, "_busy_done"}, {busy1, busy3, done1, done3}, 4'b0000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s;
        int t;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_groups = '0; ifm_ready = 1'b0;
        clear_events();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single group, rd_data = address, latency 1 vs 3
        data_is_addr = 1'b1; ifm_ready = 1'b1; rand_ready = 1'b0;
        clear_events();
        start_job(32'h100, 1, s);
        wait_idle(60, 1'b0);
        chk("lat1_first_rd", first_rd1, s + 1);
        chk("lat1_valid_cyc", valid_cyc1, s + 6);
        chk("lat1_done_cyc", done_cyc1, s + 7);
        chk("lat1_busy_cycles", busy_cnt1, 7);
        chk("lat1_group", first_grp1, 128'h00000103_00000102_00000101_00000100);
        chk("lat3_first_rd", first_rd3, s + 1);
        chk("lat3_valid_cyc", valid_cyc3, s + 8);
        chk("lat3_done_cyc", done_cyc3, s + 9);

        // Three groups with downstream stalled in the first hold
        data_is_addr = 1'b0; ifm_ready = 1'b0;
        clear_events();
        start_job(32'h100, 3, s);
        t = 0;
        while (!valid1 && t < 30) begin tick(); t++; end
        chk("stall_valid_rise", valid1, 1'b1);
        repeat (5) tick();
        chk("stall_valid_held", {valid1, busy1}, 2'b11);
        ifm_ready = 1'b1;
        wait_idle(100, 1'b0);
        chk("stall_done_once", done_cyc1 >= 0 ? 1 : 0, 1);

        // Empty job
        clear_events();
        start_job(32'h500, 0, s);
        wait_idle(10, 1'b0);
        chk("empty_busy1", busy_cnt1, 1);
        chk("empty_busy3", busy_cnt3, 1);
        chk("empty_done1", done_cyc1, s + 1);
        chk("empty_done3", done_cyc3, s + 1);
        chk("empty_no_rd", {first_rd1, first_rd3}, {-32'sd1, -32'sd1});

        // Address wrap
        start_job(32'hFFFF_FFFE, 1, s);
        wait_idle(60, 1'b0);

        // Random jobs with random back-pressure and ignored starts while busy
        rand_ready = 1'b1;
        for (int j = 0; j < 25; j++) begin
            data_is_addr = $urandom_range(0, 1) != 0;
            start_job($urandom, $urandom_range(1, 4), s);
            wait_idle(400, 1'b1);
        end
        rand_ready = 1'b0;
        ifm_ready  = 1'b1;

        // Reset during beat 2 of the first read burst
        data_is_addr = 1'b1;
        start_job(32'h2000, 2, s);
        tick();
        tick();
        chk("pre_reset_rd_en", {rd_en1, rd_en3}, 2'b11);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        exp_a1.delete(); exp_a3.delete(); exp_g1.delete(); exp_g3.delete();
        exp_done1 = 0; exp_done3 = 0; got_done1 = 0; got_done3 = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_reset_idle", {valid1, valid3, busy1, busy3}, 4'b0000);
        end
        start_job(32'h3000, 2, s);
        wait_idle(100, 1'b0);

        tick();
        chk("done_count1", got_done1, exp_done1);
        chk("done_count3", got_done3, exp_done3);
        chk("leftover_addr", exp_a1.size() + exp_a3.size(), 0);
        chk("leftover_grp", exp_g1.size() + exp_g3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifm_fetch_controller.md
IFM_FETCH_CONTROLLER -- requirements
Module: ifm_fetch_controller

Interface
REQ-001 Parameter: ADDR_W, default 32, width of the read address.
REQ-002 Parameter: BEAT_W, default 32, width of one RAM read beat.
REQ-003 Parameter: RD_LAT, default 1, fixed RAM read latency in cycles (legal 1..4).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a fetch job; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first RAM word address of the job; latched on accepted start.
REQ-008 num_groups  input  16  number of 4-beat groups in the job; latched on accepted start.
REQ-009 rd_en_next  output  1  RAM read enable.
REQ-010 addr_ram_next_rd  output  ADDR_W  RAM read address, valid while rd_en_next=1.
REQ-011 rd_data  input  BEAT_W  RAM read data, valid exactly RD_LAT cycles after rd_en_next.
REQ-012 ifm_data_out  output  4*BEAT_W  assembled group; beat k in bits [k*BEAT_W +: BEAT_W].
REQ-013 ifm_data_valid  output  1  ifm_data_out holds a complete group.
REQ-014 ifm_ready  input  1  downstream accepts group when ifm_data_valid=1 and ifm_ready=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when the last group is accepted (or an empty job is accepted).

Function
REQ-017 FSM states IDLE, READ, WAIT, HOLD, DONE; registered state, next-state decode combinational.
REQ-018 IDLE: start=1 latches base_addr into the address counter, num_groups into the remaining counter; next state READ, or DONE if num_groups=0.
REQ-019 start while not IDLE is ignored; no queuing.
REQ-020 READ: rd_en_next=1 for exactly 4 consecutive cycles; address counter increments by 1 per cycle; 2-bit beat counter 0..3; after beat 3 go to WAIT.
REQ-021 Address counter is not reset between groups; group n starts at base_addr+4n; increment wraps modulo 2^ADDR_W.
REQ-022 A RD_LAT-deep shift of rd_en_next plus beat index marks returning data; each marked rd_data is written into lane = its beat index at the next rising edge.
REQ-023 WAIT: held until the beat-3 data is captured; that same edge sets ifm_data_valid=1 and enters HOLD.
REQ-024 With RD_LAT=1: start sampled at cycle 0 -> rd_en_next high cycles 1-4 -> ifm_data_valid high from cycle 6.
REQ-025 HOLD: ifm_data_out and ifm_data_valid stable until handshake; no reads issued.
REQ-026 Handshake in HOLD: ifm_data_valid cleared next edge, remaining counter decrements; next state READ if remaining after decrement is nonzero, else DONE.
REQ-027 ifm_ready while ifm_data_valid=0 has no effect.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; busy=1 during DONE.
REQ-029 num_groups=65535 is legal; remaining counter never underflows.
REQ-030 ifm_data_out bits not yet overwritten retain previous group's values; only lane writes change them.

Reset
REQ-031 rst=1 asynchronously forces: state IDLE, rd_en_next=0, addr_ram_next_rd=0, ifm_data_out=0, ifm_data_valid=0, busy=0, done=0, beat/remaining/latency-pipe counters=0.
REQ-032 Reset mid-job aborts it; read data returning after reset release is discarded; a new start is required.

Verification
REQ-033 base_addr=0x100, num_groups=1, RD_LAT=1, ifm_ready=1, rd_data=addr -> addresses 0x100-0x103 cycles 1-4, ifm_data_out=0x00000103_00000102_00000101_00000100 at cycle 6, done pulse cycle 7.
REQ-034 num_groups=3, ifm_ready held 0 for 5 cycles in HOLD of group 1 -> data stable, no rd_en_next in HOLD, group 2 reads 0x104-0x107 after acceptance, done once.
REQ-035 num_groups=0, start=1 -> no rd_en_next, busy 1 cycle, done pulse 1 cycle after start.
REQ-036 base_addr=0xFFFFFFFE, num_groups=1 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-037 rst asserted during READ beat 2 -> all outputs reset immediately; after release no ifm_data_valid until new start.
REQ-038 start pulsed during READ/HOLD -> ignored; job length and addresses unchanged; RD_LAT=3 run -> ifm_data_valid 2 cycles later than REQ-024.
